audio_sample_scheduler: RTL and testbench

Sequences L/R audio sample pairs into HDMI audio sample packets. Buffers incoming stereo samples in a small FIFO, gathers up to four pairs per packet, and presents them to the audio sample packet builder with the matching IEC 60958 frame counter, present mask and valid/user bits. Hands each packet to the data-island packet arbiter over a valid/ack handshake. Sits between the audio capture domain (already synchronized to the pixel clock) and the packet builder/arbiter in the HDMI top.

---
 rtl/audio_sample_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_audio_sample_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_scheduler.sv
// Gathers buffered L/R sample pairs into HDMI audio sample packets and offers them over a valid/ack handshake.
// Optional sticky drop flag: define AUDIO_OVERFLOW_FLAG_EN.
module audio_sample_scheduler #(
  parameter int   FIFO_DEPTH    = 8,
  parameter logic VALID_BIT     = 1'b0,
  parameter logic USER_DATA_BIT = 1'b0
) (
  input  logic                          clk_pixel,
  input  logic                          reset,
  input  logic                          audio_sample_valid,
  input  logic [47:0]                   audio_sample_pair,
  input  logic                          load_request,
  output logic                          packet_valid,
  input  logic                          packet_ack,
  output logic [7:0]                    frame_counter,
  output logic [191:0]                  audio_sample_word,
  output logic [3:0]                    audio_sample_word_present,
  output logic [7:0]                    valid_bit,
  output logic [7:0]                    user_data_bit,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [1:0]                    dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // Handshake: packet_valid is high exactly while in HOLD with every packet
  // output frozen; a cycle with packet_valid=1 and packet_ack=1 transfers the
  // packet. packet_ack outside HOLD and load_request outside IDLE are ignored.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [47:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [2:0]     k_q, k_d;
  logic [7:0]     fc_q, fc_d;
  logic [191:0]   word_q, word_d;
  logic [3:0]     present_q, present_d;
  logic           pv_q, pv_d;

  logic           full;
  logic           pop;
  logic           push;
  logic [8:0]     fc_sum;

  assign full = (count_q == CW'(FIFO_DEPTH));
  assign pop  = (state_q == LOAD) && (count_q != '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted while loading.
  assign push = audio_sample_valid && (!full || pop);

  assign fc_sum = {1'b0, fc_q} + {6'b0, k_q};

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    k_d       = k_q;
    fc_d      = fc_q;
    word_d    = word_q;
    present_d = present_q;
    pv_d      = pv_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);

    case (state_q)
      IDLE: begin
        if (load_request && (count_q != '0)) begin
          state_d = LOAD;
          k_d     = 3'd0;
        end
      end
      LOAD: begin
        if (pop) begin
          for (int i = 0; i < 4; i++) begin
            if (k_q[1:0] == i[1:0]) begin
              word_d[48*i +: 48] = mem_q[rd_ptr_q];
              present_d[i]       = 1'b1;
            end
          end
          k_d = k_q + 3'd1;
        end
        // Pairs pushed during LOAD keep the packet growing while data remains.
        if (!pop || (k_q == 3'd3) || (count_d == '0)) begin
          state_d = HOLD;
          pv_d    = 1'b1;
        end
      end
      HOLD: begin
        if (packet_ack) begin
          fc_d      = (fc_sum >= 9'd192) ? 8'(fc_sum - 9'd192) : fc_sum[7:0];
          word_d    = '0;
          present_d = '0;
          pv_d      = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      k_q       <= 3'd0;
      fc_q      <= 8'd0;
      word_q    <= '0;
      present_q <= '0;
      pv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      k_q       <= k_d;
      fc_q      <= fc_d;
      word_q    <= word_d;
      present_q <= present_d;
      pv_q      <= pv_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk_pixel) begin
    if (push) begin
      mem_q[wr_ptr_q] <= audio_sample_pair;
    end
  end

`ifdef AUDIO_OVERFLOW_FLAG_EN
  logic drop;
  logic overflow_q, overflow_d;

  assign drop = audio_sample_valid && full && !pop;

  always_comb begin
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

  assign packet_valid              = pv_q;
  assign frame_counter             = fc_q;
  assign audio_sample_word         = word_q;
  assign audio_sample_word_present = present_q;
  assign valid_bit                 = {8{VALID_BIT}};
  assign user_data_bit             = {8{USER_DATA_BIT}};
  assign fifo_count                = count_q;
  assign dbg_state                 = state_q;

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Self-checking bench for audio_sample_scheduler: FIFO/packet model with an expected-pair queue.
module tb_audio_sample_scheduler;

  localparam int DEPTH = 8;

`ifdef AUDIO_OVERFLOW_FLAG_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic         clk_pixel = 1'b0;
  logic         reset = 1'b1;
  logic         audio_sample_valid = 1'b0;
  logic [47:0]  audio_sample_pair = '0;
  logic         load_request = 1'b0;
  logic         packet_valid;
  logic         packet_ack = 1'b0;
  logic [7:0]   frame_counter;
  logic [191:0] audio_sample_word;
  logic [3:0]   audio_sample_word_present;
  logic [7:0]   valid_bit;
  logic [7:0]   user_data_bit;
  logic [3:0]   fifo_count;
  logic         overflow;
  logic [1:0]   dbg_state;

  audio_sample_scheduler #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_pixel                 (clk_pixel),
    .reset                     (reset),
    .audio_sample_valid        (audio_sample_valid),
    .audio_sample_pair         (audio_sample_pair),
    .load_request              (load_request),
    .packet_valid              (packet_valid),
    .packet_ack                (packet_ack),
    .frame_counter             (frame_counter),
    .audio_sample_word         (audio_sample_word),
    .audio_sample_word_present (audio_sample_word_present),
    .valid_bit                 (valid_bit),
    .user_data_bit             (user_data_bit),
    .fifo_count                (fifo_count),
    .overflow                  (overflow),
    .dbg_state                 (dbg_state)
  );

  // clock / reset
  always #5 clk_pixel = ~clk_pixel;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard state
  int           n_cmp = 0;
  int           n_err = 0;
  logic [47:0]  exp_q[$];
  int           fifo_cnt = 0;
  int           exp_fc = 0;
  int           exp_k = 0;
  logic [191:0] exp_word;
  logic [3:0]   exp_present;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    audio_sample_valid = 1'b0;
    load_request = 1'b0;
    packet_ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
    fifo_cnt = 0;
    exp_fc = 0;
  endtask

  function automatic logic [47:0] rand_pair();
    logic [47:0] d;
    d[23:0]  = 24'($urandom());
    d[47:24] = 24'($urandom());
    return d;
  endfunction

  // driver: one push, modelled as dropped when the FIFO is full and nothing pops
  task automatic push_pair(input logic [47:0] d);
    audio_sample_valid = 1'b1;
    audio_sample_pair  = d;
    tick();
    audio_sample_valid = 1'b0;
    if (fifo_cnt < DEPTH) begin
      exp_q.push_back(d);
      fifo_cnt++;
    end
    check("push_count", fifo_count, fifo_cnt);
  endtask

  // pops the expected slots from the scoreboard queue
  task automatic build_expected();
    exp_k = (fifo_cnt < 4) ? fifo_cnt : 4;
    exp_word = '0;
    exp_present = '0;
    for (int i = 0; i < exp_k; i++) begin
      exp_word[48*i +: 48] = exp_q.pop_front();
      exp_present[i] = 1'b1;
    end
    fifo_cnt -= exp_k;
  endtask

  task automatic check_packet();
    check("pkt_valid", packet_valid, 1'b1);
    check("pkt_present", audio_sample_word_present, exp_present);
    check("pkt_word", audio_sample_word, exp_word);
    check("pkt_fc", frame_counter, exp_fc);
    check("pkt_fifo", fifo_count, fifo_cnt);
    check("valid_bits", valid_bit, 8'h00);
    check("user_bits", user_data_bit, 8'h00);
  endtask

  task automatic load_and_check();
    int lat;
    build_expected();
    load_request = 1'b1;
    tick();
    load_request = 1'b0;
    lat = 0;
    while (!packet_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("load_latency", lat, exp_k);
    check_packet();
  endtask

  task automatic ack_and_check();
    packet_ack = 1'b1;
    tick();
    packet_ack = 1'b0;
    exp_fc = (exp_fc + exp_k) % 192;
    check("ack_valid", packet_valid, 1'b0);
    check("ack_fc", frame_counter, exp_fc);
    check("ack_present", audio_sample_word_present, 4'b0000);
    check("ack_word", audio_sample_word, 192'd0);
  endtask

  task automatic run_packet(input int n);
    for (int i = 0; i < n; i++) push_pair(rand_pair());
    load_and_check();
    ack_and_check();
  endtask

  initial begin
    logic [47:0] d;
    int lat;

    // reset values
    do_reset();
    check("rst_valid", packet_valid, 1'b0);
    check("rst_fc", frame_counter, 8'd0);
    check("rst_word", audio_sample_word, 192'd0);
    check("rst_present", audio_sample_word_present, 4'b0000);
    check("rst_fifo", fifo_count, 4'd0);
    check("rst_ovf", overflow, 1'b0);

    // four-pair packet with known data
    for (int i = 0; i < 4; i++) push_pair({24'(32'h100 + i), 24'(i)});
    load_and_check();
    check("word0", audio_sample_word[47:0], 48'h000100_000000);
    ack_and_check();
    check("fc_after_first", frame_counter, 8'd4);

    // stray ack in IDLE and request with an empty FIFO do nothing
    packet_ack = 1'b1;
    tick();
    packet_ack = 1'b0;
    check("idle_ack_fc", frame_counter, 8'd4);
    load_request = 1'b1;
    tick();
    load_request = 1'b0;
    tick();
    tick();
    check("empty_req_valid", packet_valid, 1'b0);

    // partial packet
    run_packet(2);
    check("fc_partial", frame_counter, 8'd6);

    // frame counter wrap sequences
    do_reset();
    for (int p = 0; p < 47; p++) run_packet(4);
    check("fc_188", frame_counter, 8'd188);
    run_packet(4);
    check("fc_wrap_0", frame_counter, 8'd0);
    for (int p = 0; p < 47; p++) run_packet(4);
    run_packet(2);
    check("fc_190", frame_counter, 8'd190);
    run_packet(4);
    check("fc_wrap_2", frame_counter, 8'd2);
    for (int p = 0; p < 47; p++) run_packet(4);
    run_packet(1);
    check("fc_191", frame_counter, 8'd191);
    run_packet(1);
    check("fc_wrap_191", frame_counter, 8'd0);

    // long HOLD with ack low while the FIFO fills and overflows
    do_reset();
    for (int i = 0; i < 4; i++) push_pair(rand_pair());
    load_and_check();
    for (int i = 0; i < 20; i++) begin
      if (i < 9) push_pair(rand_pair());
      else tick();
    end
    check_packet();
    check("hold_fifo_full", fifo_count, 4'd8);
    check("hold_ovf", overflow, OVF_EXP);
    ack_and_check();
    load_and_check();
    ack_and_check();
    load_and_check();
    ack_and_check();
    check("drain_fifo", fifo_count, 4'd0);
    check("ovf_sticky", overflow, OVF_EXP);

    // push into a full FIFO during a LOAD pop
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_pair(rand_pair());
    build_expected();
    d = rand_pair();
    load_request = 1'b1;
    tick();
    load_request = 1'b0;
    audio_sample_valid = 1'b1;
    audio_sample_pair  = d;
    tick();
    audio_sample_valid = 1'b0;
    exp_q.push_back(d);
    fifo_cnt++;
    check("pushpop_count", fifo_count, 4'd8);
    check("pushpop_ovf", overflow, 1'b0);
    lat = 1;
    while (!packet_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("pushpop_latency", lat, 4);
    check_packet();
    ack_and_check();
    load_and_check();
    ack_and_check();
    load_and_check();
    ack_and_check();
    check("pushpop_drain", fifo_count, 4'd0);
    check("pushpop_ovf_end", overflow, 1'b0);

    // reset while holding a packet at frame 100
    while (exp_fc != 100) run_packet(((100 - exp_fc) >= 4) ? 4 : (100 - exp_fc));
    for (int i = 0; i < 6; i++) push_pair(rand_pair());
    load_and_check();
    check("hold_fc_100", frame_counter, 8'd100);
    reset = 1'b1;
    tick();
    check("midrst_valid", packet_valid, 1'b0);
    check("midrst_fc", frame_counter, 8'd0);
    check("midrst_fifo", fifo_count, 4'd0);
    check("midrst_present", audio_sample_word_present, 4'b0000);
    check("midrst_word", audio_sample_word, 192'd0);
    check("midrst_ovf", overflow, 1'b0);
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
